// File: rtl/tdm_dmux8.sv
// tdm_dmux8 -- receive-side 8-way time-division demultiplexer.
//
// Collects 8 consecutive accepted words (slot 0 marked by sof) into a shadow
// buffer. When the 8th word arrives, the whole frame moves to the output
// registers a..h in one step, so a partial frame never shows on the outputs.
//
// Ports
//   clock       rising-edge clock for all state
//   reset_n     synchronous, active-low reset
//   in          serial TDM data word (WIDTH bits)
//   in_valid    qualifies in; one word is accepted per edge with in_valid=1
//   sof         start-of-frame marker, meaningful only with in_valid=1
//   a..h        committed frame slots 0..7
//   frame_valid one-cycle pulse in the cycle a new frame appears on a..h
//   err         one-cycle framing-error pulse
//   slot        index of the next slot expected
//   frames      count of committed frames, wraps 255 -> 0
module tdm_dmux8 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic             frame_valid,
  output logic             err,
  output logic [2:0]       slot,
  output logic [7:0]       frames
);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q [8];
  logic [WIDTH-1:0] shadow_d [8];
  logic [WIDTH-1:0] out_q    [8];
  logic [WIDTH-1:0] out_d    [8];
  logic             frame_valid_q, frame_valid_d;
  logic             err_q, err_d;
  logic [7:0]       frames_q, frames_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    out_d         = out_q;
    frame_valid_d = 1'b0;
    err_d         = 1'b0;
    frames_d      = frames_q;

    if (in_valid) begin
      unique case (state_q)
        IDLE: begin
          if (sof) begin
            shadow_d[0] = in;
            cnt_d       = 3'd1;
            state_d     = RECV;
          end else begin
            // Word outside a frame: drop it, flag it, stay aligned at slot 0.
            err_d = 1'b1;
          end
        end

        RECV: begin
          if (sof) begin
            // Early sof abandons the partial frame and restarts at slot 0.
            err_d       = 1'b1;
            shadow_d[0] = in;
            cnt_d       = 3'd1;
          end else begin
            shadow_d[cnt_q] = in;
            if (cnt_q == 3'd7) begin
              // The 8th word bypasses the shadow so the commit needs no extra cycle.
              for (int unsigned i = 0; i < 7; i++) begin
                out_d[i] = shadow_q[i];
              end
              out_d[7]      = in;
              cnt_d         = 3'd0;
              state_d       = IDLE;
              frame_valid_d = 1'b1;
              frames_d      = frames_q + 8'd1;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
      frames_q      <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        shadow_q[i] <= '0;
        out_q[i]    <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frame_valid_q <= frame_valid_d;
      err_q         <= err_d;
      frames_q      <= frames_d;
      for (int unsigned i = 0; i < 8; i++) begin
        shadow_q[i] <= shadow_d[i];
        out_q[i]    <= out_d[i];
      end
    end
  end

  assign a           = out_q[0];
  assign b           = out_q[1];
  assign c           = out_q[2];
  assign d           = out_q[3];
  assign e           = out_q[4];
  assign f           = out_q[5];
  assign g           = out_q[6];
  assign h           = out_q[7];
  assign frame_valid = frame_valid_q;
  assign err         = err_q;
  assign slot        = cnt_q;
  assign frames      = frames_q;

endmodule

// File: tb/tb_tdm_dmux8.sv
// tb_tdm_dmux8 -- directed self-checking bench for tdm_dmux8 (WIDTH=16).
module tb_tdm_dmux8;

  logic        clock;
  logic        reset_n;
  logic [15:0] in_w;
  logic        in_valid;
  logic        sof;
  logic [15:0] a, b, c, d, e, f, g, h;
  logic        frame_valid;
  logic        err;
  logic [2:0]  slot;
  logic [7:0]  frames;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int err_cnt = 0;

  tdm_dmux8 #(.WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .in(in_w), .in_valid(in_valid), .sof(sof),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .frame_valid(frame_valid), .err(err), .slot(slot), .frames(frames)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse counters and mutual-exclusion check, sampled away from the active edge.
  always @(negedge clock) begin
    if (frame_valid === 1'b1) fv_cnt++;
    if (err === 1'b1) err_cnt++;
    if (frame_valid === 1'b1 || err === 1'b1) begin
      checks++;
      if ((frame_valid && err) !== 1'b0) begin
        errors++;
        $display("FAIL excl: frame_valid=%b err=%b both high, required not both", frame_valid, err);
      end
    end
  end

  // One clock: inputs applied at negedge, outputs settle #1 after posedge.
  task automatic put(input logic [15:0] data, input logic v, input logic s);
    @(negedge clock);
    in_w = data; in_valid = v; sof = s;
    @(posedge clock);
    #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) put(16'h0000, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; in_valid = 1'b0; sof = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a, b, c, d, e, f, g, h} !== 128'h0) begin
      errors++; $display("FAIL reset_outs: got %h required 0", {a, b, c, d, e, f, g, h});
    end
    checks++;
    if ({frame_valid, err, slot, frames} !== 13'h0) begin
      errors++; $display("FAIL reset_ctl: fv=%b err=%b slot=%0d frames=%0d required all 0",
                         frame_valid, err, slot, frames);
    end
  endtask

  task automatic test_single_frame();
    int fv0, er0;
    do_reset();
    fv0 = fv_cnt; er0 = err_cnt;
    for (int i = 1; i <= 8; i++) begin
      put(16'(i), 1'b1, i == 1);
      if (i < 8) begin
        checks++;
        if (slot !== 3'(i)) begin
          errors++; $display("FAIL s1_slot%0d: got %0d required %0d", i, slot, i);
        end
      end
    end
    checks++;
    if (frame_valid !== 1'b1) begin
      errors++; $display("FAIL s1_fv: got %b required 1", frame_valid);
    end
    checks++;
    if ({a, b, c, d, e, f, g, h} !== 128'h0001_0002_0003_0004_0005_0006_0007_0008) begin
      errors++; $display("FAIL s1_data: got %h required 0001..0008", {a, b, c, d, e, f, g, h});
    end
    checks++;
    if (frames !== 8'd1 || slot !== 3'd0) begin
      errors++; $display("FAIL s1_frames: frames=%0d slot=%0d required 1 and 0", frames, slot);
    end
    gap(2);
    checks++;
    if (frame_valid !== 1'b0 || fv_cnt - fv0 !== 1 || err_cnt - er0 !== 0) begin
      errors++; $display("FAIL s1_pulse: fv=%b fv_pulses=%0d err_pulses=%0d required 0,1,0",
                         frame_valid, fv_cnt - fv0, err_cnt - er0);
    end
  endtask

  task automatic test_gaps();
    int fv0, er0;
    do_reset();
    fv0 = fv_cnt; er0 = err_cnt;
    for (int i = 1; i <= 8; i++) begin
      put(16'(i), 1'b1, i == 1);
      if (i < 8) begin
        gap(3);
        checks++;
        if ({a, b, c, d, e, f, g, h} !== 128'h0 || slot !== 3'(i)) begin
          errors++; $display("FAIL s2_hold%0d: outs=%h slot=%0d required 0 and %0d",
                             i, {a, b, c, d, e, f, g, h}, slot, i);
        end
      end
    end
    checks++;
    if ({a, b, c, d, e, f, g, h} !== 128'h0001_0002_0003_0004_0005_0006_0007_0008 || frame_valid !== 1'b1) begin
      errors++; $display("FAIL s2_data: got %h fv=%b required 0001..0008 fv=1",
                         {a, b, c, d, e, f, g, h}, frame_valid);
    end
    gap(1);
    checks++;
    if (frames !== 8'd1 || fv_cnt - fv0 !== 1 || err_cnt - er0 !== 0) begin
      errors++; $display("FAIL s2_count: frames=%0d fv_pulses=%0d err_pulses=%0d required 1,1,0",
                         frames, fv_cnt - fv0, err_cnt - er0);
    end
  endtask

  task automatic test_sof_error();
    int er0;
    do_reset();
    er0 = err_cnt;
    for (int i = 0; i < 4; i++) put(16'h0C00 + 16'(i), 1'b1, i == 0);
    put(16'hAAAA, 1'b1, 1'b1);
    checks++;
    if (err !== 1'b1 || slot !== 3'd1 || frame_valid !== 1'b0) begin
      errors++; $display("FAIL s3_err: err=%b slot=%0d fv=%b required 1,1,0", err, slot, frame_valid);
    end
    for (int i = 1; i <= 7; i++) put(16'hB000 + 16'(i), 1'b1, 1'b0);
    checks++;
    if ({a, b, c, d, e, f, g, h} !== 128'hAAAA_B001_B002_B003_B004_B005_B006_B007) begin
      errors++; $display("FAIL s3_data: got %h required AAAA,B001..B007", {a, b, c, d, e, f, g, h});
    end
    gap(1);
    checks++;
    if (frames !== 8'd1 || err_cnt - er0 !== 1) begin
      errors++; $display("FAIL s3_count: frames=%0d err_pulses=%0d required 1,1", frames, err_cnt - er0);
    end
  endtask

  task automatic test_idle_no_sof();
    int er0;
    do_reset();
    er0 = err_cnt;
    put(16'h1234, 1'b1, 1'b0);
    checks++;
    if (err !== 1'b1 || slot !== 3'd0) begin
      errors++; $display("FAIL s4_err: err=%b slot=%0d required 1,0", err, slot);
    end
    gap(1);
    checks++;
    if (err !== 1'b0 || err_cnt - er0 !== 1 || {a, b, c, d, e, f, g, h} !== 128'h0 || frames !== 8'd0) begin
      errors++; $display("FAIL s4_after: err=%b pulses=%0d outs=%h frames=%0d required 0,1,0,0",
                         err, err_cnt - er0, {a, b, c, d, e, f, g, h}, frames);
    end
  endtask

  task automatic test_reset_mid();
    int er0;
    do_reset();
    er0 = err_cnt;
    for (int i = 0; i < 5; i++) put(16'h0E00 + 16'(i), 1'b1, i == 0);
    // Reset with a valid non-sof word present: reset must win.
    @(negedge clock);
    reset_n = 1'b0; in_w = 16'hDEAD; in_valid = 1'b1; sof = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    checks++;
    if (slot !== 3'd0 || frame_valid !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL s5_rst: slot=%0d fv=%b err=%b required 0,0,0", slot, frame_valid, err);
    end
    for (int i = 0; i < 8; i++) put(16'h0100 + 16'(i), 1'b1, i == 0);
    checks++;
    if ({a, b, c, d, e, f, g, h} !== 128'h0100_0101_0102_0103_0104_0105_0106_0107 || frames !== 8'd1) begin
      errors++; $display("FAIL s5_data: got %h frames=%0d required 0100..0107 frames=1",
                         {a, b, c, d, e, f, g, h}, frames);
    end
    gap(1);
    checks++;
    if (err_cnt - er0 !== 0) begin
      errors++; $display("FAIL s5_noerr: err pulses=%0d required 0", err_cnt - er0);
    end
  endtask

  task automatic test_back_to_back();
    int fv0, er0;
    do_reset();
    fv0 = fv_cnt; er0 = err_cnt;
    for (int k = 0; k < 256; k++) begin
      for (int j = 0; j < 8; j++) put(16'(k * 16 + j), 1'b1, j == 0);
      if (k == 254) begin
        checks++;
        if (frames !== 8'd255) begin
          errors++; $display("FAIL s6_255: frames=%0d required 255", frames);
        end
      end
    end
    checks++;
    if (frames !== 8'd0 || frame_valid !== 1'b1) begin
      errors++; $display("FAIL s6_wrap: frames=%0d fv=%b required 0,1", frames, frame_valid);
    end
    checks++;
    if (a !== 16'h0FF0 || h !== 16'h0FF7) begin
      errors++; $display("FAIL s6_last: a=%h h=%h required 0FF0 0FF7", a, h);
    end
    gap(1);
    checks++;
    if (fv_cnt - fv0 !== 256 || err_cnt - er0 !== 0) begin
      errors++; $display("FAIL s6_pulses: fv=%0d err=%0d required 256,0", fv_cnt - fv0, err_cnt - er0);
    end
  endtask

  initial begin
    reset_n = 1'b0; in_w = '0; in_valid = 1'b0; sof = 1'b0;
    test_reset();
    test_single_frame();
    test_gaps();
    test_sof_error();
    test_idle_no_sof();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_dmux8.md
TDM_DMUX8 -- requirements
Module: tdm_dmux8

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the width of each data word.
REQ-002 The block SHALL have port clock  input  1  the single rising-edge clock for all state.
REQ-003 The block SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port in  input  WIDTH  the serial time-division data word.
REQ-005 The block SHALL have port in_valid  input  1  qualifies in; a word is accepted on each rising clock edge with in_valid=1.
REQ-006 The block SHALL have port sof  input  1  start-of-frame marker; it is meaningful only when in_valid=1 and marks slot 0.
REQ-007 The block SHALL have ports a,b,c,d,e,f,g,h  output  WIDTH each  committed frame slots 0..7.
REQ-008 The block SHALL have port frame_valid  output  1  a one-cycle pulse that fires when a new frame commits.
REQ-009 The block SHALL have port err  output  1  a one-cycle framing-error pulse.
REQ-010 The block SHALL have port slot  output  3  the index of the next slot expected.
REQ-011 The block SHALL have port frames  output  8  the count of committed frames.

Function
REQ-012 The block SHALL be the receive-side counterpart of an 8-way time-multiplexed word transmitter. It SHALL distribute 8 consecutive accepted words into slots a..h, with slot 0 first.
REQ-013 The block SHALL have two states, IDLE and RECV. It SHALL hold the slot counter cnt[2:0] (driven on slot), an 8xWIDTH shadow buffer and an 8xWIDTH output buffer.
REQ-014 In IDLE with in_valid=1 and sof=1, the block SHALL write in to shadow[0], set cnt=1 and go to RECV.
REQ-015 In IDLE with in_valid=1 and sof=0, the block SHALL discard the word and pulse err the next cycle. cnt SHALL stay 0.
REQ-016 In RECV with in_valid=1, sof=0 and cnt<7, the block SHALL write in to shadow[cnt] and increment cnt.
REQ-017 In RECV with in_valid=1, sof=0 and cnt=7, the block SHALL do all of the following on the same edge:
- write the word;
- copy all 8 slots (shadow[0..6] plus this word) into the output buffer;
- set cnt=0 and go to IDLE.
REQ-018 After the commit of REQ-017, frame_valid SHALL be 1 for exactly the following cycle. a..h SHALL present the new frame in that same cycle, so latency is 1 cycle from the 8th accepted edge.
REQ-019 In RECV with in_valid=1 and sof=1, the block SHALL treat the event as a framing error:
- pulse err the next cycle;
- abandon the partial frame, with no commit;
- write in to shadow[0], set cnt=1 and stay in RECV.
REQ-020 When in_valid=0, the block SHALL hold all state. Gaps of any length between words SHALL be tolerated.
REQ-021 a..h SHALL change only on commit. A partial frame SHALL never be visible on a..h.
REQ-022 frames SHALL increment by 1 on each commit and wrap from 255 to 0.
REQ-023 frame_valid and err SHALL never be 1 in the same cycle. Each SHALL be a registered output.

Reset
REQ-024 When reset_n=0 at a rising edge, the block SHALL enter IDLE and clear cnt, slot, frames, frame_valid and err to 0.
REQ-025 When reset_n=0 at a rising edge, the block SHALL clear a..h and the shadow buffer to 0.
REQ-026 Reset SHALL take priority over in_valid. A reset during RECV SHALL discard the partial frame with no commit and no err.
REQ-027 The first word accepted after reset is released SHALL be processed per REQ-014/REQ-015.

Verification
REQ-028 Scenario 1: send words 0x0001..0x0008 on 8 consecutive cycles, with sof on the first. Required: a=0x0001, h=0x0008, frame_valid for 1 cycle, frames=1, err never set.
REQ-029 Scenario 2: repeat Scenario 1 with in_valid=0 for 3 cycles between each word. Required: the same outputs, and a..h unchanged until the 8th word.
REQ-030 Scenario 3: send 4 words with sof on the first, then sof with 0xAAAA, then 7 more words 0xB001..0xB007. Required:
- err pulses once after the 0xAAAA edge;
- a=0xAAAA and h=0xB007;
- frames=1.
REQ-031 Scenario 4: while IDLE, send 0x1234 with sof=0. Required: err pulses once, slot stays 0, and a..h remain 0.
REQ-032 Scenario 5: send 5 words of a frame, assert reset_n=0 for 1 cycle, then send a full frame 0x0100..0x0107. Required: no err, a=0x0100, frames=1.
REQ-033 Scenario 6: send 256 back-to-back complete frames. Required: frames wraps to 0, with exactly 256 frame_valid pulses.
